// File: rtl/pe_pkg.sv
// Shared constants and helpers for the multi-lane PE: default widths, the
// adder-tree result width and the output saturation clamp.
package pe_pkg;

   localparam int DEF_NUM_LANES = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ACC_W     = 32;
   localparam int DEF_SHIFT_W   = 5;

   // Working width of the clamp; must cover ACC_W+1.
   localparam int CLAMP_W = 64;

   typedef struct packed {
      logic [CLAMP_W-1:0] value;
      logic               sat;
   } clamp_t;

   function automatic int sum_width(input int data_w, input int num_lanes);
      return 2*data_w + $clog2(num_lanes);
   endfunction

   function automatic clamp_t sat_clamp(input logic signed [CLAMP_W-1:0] value,
                                        input logic                      signed_mode,
                                        input int                        data_w);
      logic signed [CLAMP_W-1:0] hi;
      logic signed [CLAMP_W-1:0] lo;
      clamp_t                    res;
      hi = signed_mode ? (64'sd1 <<< (data_w - 1)) - 64'sd1 : (64'sd1 <<< data_w) - 64'sd1;
      lo = signed_mode ? -(64'sd1 <<< (data_w - 1)) : 64'sd0;
      res.value = value;
      res.sat   = 1'b0;
      if (value > hi) begin
         res.value = hi;
         res.sat   = 1'b1;
      end else if (value < lo) begin
         res.value = lo;
         res.sat   = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/multi_pe_mac_if.sv
// Operand/control and result bundle between the IFM/weight buffers, the PE
// and the OFM writer. master drives operands, slave is the PE.
interface multi_pe_mac_if #(
   parameter int NUM_LANES = pe_pkg::DEF_NUM_LANES,
   parameter int DATA_W    = pe_pkg::DEF_DATA_W,
   parameter int SHIFT_W   = pe_pkg::DEF_SHIFT_W
) ();
   logic [NUM_LANES*DATA_W-1:0] ifm;
   logic [NUM_LANES*DATA_W-1:0] weight;
   logic                        signed_mode;
   logic                        pe_en;
   logic                        pe_finish;
   logic [SHIFT_W-1:0]          shift;
   logic                        relu_en;
   logic [DATA_W-1:0]           ofm;
   logic                        valid;
   logic                        sat;
   logic [15:0]                 beat_cnt;

   modport master (
      output ifm, weight, signed_mode, pe_en, pe_finish, shift, relu_en,
      input  ofm, valid, sat, beat_cnt
   );

   modport slave (
      input  ifm, weight, signed_mode, pe_en, pe_finish, shift, relu_en,
      output ofm, valid, sat, beat_cnt
   );
endinterface

// File: rtl/pe_requant.sv
// Combinational requantiser: round-half-up arithmetic right shift, optional
// ReLU, then saturation to DATA_W signed or unsigned.
module pe_requant
   import pe_pkg::*;
#(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SHIFT_W = DEF_SHIFT_W
) (
   input  logic signed [ACC_W-1:0] i_total,
   input  logic [SHIFT_W-1:0]      i_shift,
   input  logic                    i_relu_en,
   input  logic                    i_signed_mode,
   output logic [DATA_W-1:0]       o_ofm,
   output logic                    o_sat
);
   logic signed [ACC_W:0] w_ext;
   logic signed [ACC_W:0] w_round;
   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_shifted;
   logic signed [ACC_W:0] w_relu;
   clamp_t                w_clamp;
   logic                  w_unused;

   // One guard bit keeps the rounding add from wrapping.
   always_comb begin
      w_ext   = {i_total[ACC_W-1], i_total};
      w_round = '0;
      if (i_shift != '0) begin
         w_round = (ACC_W+1)'(1) << (i_shift - 1'b1);
      end
      w_sum     = w_ext + w_round;
      w_shifted = w_sum >>> i_shift;
      w_relu    = w_shifted;
      if (i_relu_en && w_shifted[ACC_W]) begin
         w_relu = '0;
      end
      w_clamp = sat_clamp(CLAMP_W'(w_relu), i_signed_mode, DATA_W);
   end

   assign o_ofm    = w_clamp.value[DATA_W-1:0];
   assign o_sat    = w_clamp.sat;
   assign w_unused = ^w_clamp.value[CLAMP_W-1:DATA_W];

endmodule

// File: rtl/multi_pe_mac.sv
// N-lane multiply/accumulate PE: S1 forms the lane dot product through an
// adder tree, S2 accumulates and requantises on a finish token.
module multi_pe_mac
   import pe_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int SHIFT_W   = DEF_SHIFT_W
) (
   input  logic          clk,
   input  logic          reset_n,
   multi_pe_mac_if.slave pe
);
   localparam int SUM_W  = sum_width(DATA_W, NUM_LANES);
   localparam int TREE_N = 1 << $clog2(NUM_LANES);

   logic [SUM_W-1:0]   w_node [2*TREE_N-1];
   logic [SUM_W-1:0]   r_sum;
   logic               r_v1;
   logic               r_fin1;
   logic [SHIFT_W-1:0] r_shift1;
   logic               r_relu1;
   logic               r_signed1;
   logic [ACC_W-1:0]   r_acc;
   logic [15:0]        r_cnt;
   logic [DATA_W-1:0]  r_ofm;
   logic               r_valid;
   logic               r_sat;
   logic [15:0]        r_beat_cnt;
   logic [ACC_W-1:0]   w_sum_ext;
   logic [ACC_W-1:0]   w_total;
   logic [15:0]        w_cnt_next;
   logic [DATA_W-1:0]  w_ofm;
   logic               w_sat;

   // Leaves sit at TREE_N-1.., padded to a power of two; node j sums 2j+1 and 2j+2.
   // Products wrap at SUM_W; S2 restores the true value by sign/zero extension.
   genvar g;
   generate
      for (g = 0; g < TREE_N; g++) begin : g_leaf
         if (g < NUM_LANES) begin : g_lane
            logic [SUM_W-1:0] w_a;
            logic [SUM_W-1:0] w_b;
            assign w_a = pe.signed_mode ? SUM_W'($signed(pe.ifm[g*DATA_W +: DATA_W]))
                                        : SUM_W'(pe.ifm[g*DATA_W +: DATA_W]);
            assign w_b = pe.signed_mode ? SUM_W'($signed(pe.weight[g*DATA_W +: DATA_W]))
                                        : SUM_W'(pe.weight[g*DATA_W +: DATA_W]);
            assign w_node[TREE_N-1+g] = w_a * w_b;
         end else begin : g_pad
            assign w_node[TREE_N-1+g] = '0;
         end
      end
      for (g = 0; g < TREE_N-1; g++) begin : g_tree
         assign w_node[g] = w_node[2*g+1] + w_node[2*g+2];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sum     <= '0;
         r_v1      <= 1'b0;
         r_fin1    <= 1'b0;
         r_shift1  <= '0;
         r_relu1   <= 1'b0;
         r_signed1 <= 1'b0;
      end else begin
         r_v1      <= pe.pe_en;
         r_fin1    <= pe.pe_finish;
         r_signed1 <= pe.signed_mode;
         r_sum     <= pe.pe_en ? w_node[0] : '0;
         if (pe.pe_finish) begin
            r_shift1 <= pe.shift;
            r_relu1  <= pe.relu_en;
         end
      end
   end

   always_comb begin
      w_sum_ext  = r_signed1 ? ACC_W'($signed(r_sum)) : ACC_W'(r_sum);
      w_total    = r_acc + (r_v1 ? w_sum_ext : '0);
      w_cnt_next = (r_v1 && (r_cnt != '1)) ? r_cnt + 16'd1 : r_cnt;
   end

   pe_requant #(
      .ACC_W   (ACC_W),
      .DATA_W  (DATA_W),
      .SHIFT_W (SHIFT_W)
   ) u_requant (
      .i_total       (w_total),
      .i_shift       (r_shift1),
      .i_relu_en     (r_relu1),
      .i_signed_mode (r_signed1),
      .o_ofm         (w_ofm),
      .o_sat         (w_sat)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_ofm      <= '0;
         r_valid    <= 1'b0;
         r_sat      <= 1'b0;
         r_beat_cnt <= '0;
      end else if (r_fin1) begin
         r_ofm      <= w_ofm;
         r_sat      <= w_sat;
         r_beat_cnt <= w_cnt_next;
         r_valid    <= 1'b1;
         r_acc      <= '0;
         r_cnt      <= '0;
      end else begin
         r_valid <= 1'b0;
         r_acc   <= w_total;
         r_cnt   <= w_cnt_next;
      end
   end

   assign pe.ofm      = r_ofm;
   assign pe.valid    = r_valid;
   assign pe.sat      = r_sat;
   assign pe.beat_cnt = r_beat_cnt;

endmodule
